shift_req_arbiter: RTL and testbench

- Shares one 16-bit combinational barrel shifter (left/right logical shift, 4-bit amount, Sel=0 is left) among NREQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Drives the shifter operand/control inputs from registers and captures its result in a response register.
- Returns the result with the winning requester's ID over a valid/ready response channel.

---
 rtl/shift_req_arbiter.sv | 114 +++++++++++
 tb/tb_shift_req_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_req_arbiter.sv
// rtl/shift_req_arbiter.sv - round-robin arbiter sharing one external barrel shifter among requesters
module shift_req_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int SW   = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*SW-1:0] req_amt,
  input  logic [NREQ-1:0]    req_dir,
  output logic [DW-1:0]      sh_a,
  output logic [SW-1:0]      sh_s,
  output logic               sh_sel,
  input  logic [DW-1:0]      sh_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_data,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_reg;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic           accept;
  logic [IDW:0]   cand;

  // Rotating-priority search: first valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: grab a request, spend one cycle in the shifter, then hold the result until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = SHIFT;
      SHIFT:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: accept strobe only while idle; reset masks it so nothing is granted during reset.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
    if ((state == IDLE) && grant_found && !rst) begin
      accept               = 1'b1;
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Latch the winner's operands into the shifter inputs and move the pointer past the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a   <= '0;
      sh_s   <= '0;
      sh_sel <= 1'b0;
      id_reg <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      sh_a   <= req_data[int'(grant_idx)*DW +: DW];
      sh_s   <= req_amt[int'(grant_idx)*SW +: SW];
      sh_sel <= req_dir[grant_idx];
      id_reg <= grant_idx;
      rr_ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  // Capture the shifter result once its inputs have settled for a full cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_id   <= '0;
    end else if (state == SHIFT) begin
      rsp_data <= sh_y;
      rsp_id   <= id_reg;
    end
  end

endmodule

// File: tb/tb_shift_req_arbiter.sv
// tb/tb_shift_req_arbiter.sv - self-checking bench for shift_req_arbiter
module tb_shift_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_data;
  logic [15:0] req_amt;
  logic [3:0]  req_dir;
  logic [15:0] sh_a;
  logic [3:0]  sh_s;
  logic        sh_sel;
  logic [15:0] sh_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] cur_data [4];
  logic [3:0]  cur_amt  [4];
  logic        cur_dir  [4];

  typedef struct {
    int          id;
    logic [15:0] data;
    logic [3:0]  amt;
    logic        dir;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] res;
  } exp_t;

  vec_t vecs [7];
  exp_t expq [$];

  shift_req_arbiter #(.NREQ(4), .DW(16), .SW(4), .IDW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amt(req_amt), .req_dir(req_dir),
    .sh_a(sh_a), .sh_s(sh_s), .sh_sel(sh_sel), .sh_y(sh_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared combinational barrel shifter.
  assign sh_y = sh_sel ? (sh_a >> sh_s) : (sh_a << sh_s);

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic [3:0] amt, input logic dir);
    longint v = a;
    longint p = 1;
    for (int k = 0; k < int'(amt); k++) p = p * 2;
    if (dir) v = v / p;
    else     v = (v * p) % 65536;
    return v[15:0];
  endfunction

  function automatic int ref_winner(input logic [3:0] valid, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (valid[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [15:0] op_data(input int i, input int n);
    return 16'((i + 1) * 4111 + n * 97);
  endfunction

  task automatic set_op(input int i, input logic [15:0] d, input logic [3:0] a, input logic dr);
    req_data[i*16 +: 16] = d;
    req_amt[i*4 +: 4]    = a;
    req_dir[i]           = dr;
    req_valid[i]         = 1'b1;
    cur_data[i]          = d;
    cur_amt[i]           = a;
    cur_dir[i]           = dr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", busy, 0);
    tick;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (expq.size() == 0) begin
      chk({tag, "_unexpected_rsp"}, 1, 0);
    end else begin
      e = expq.pop_front();
      chk({tag, "_rsp_data"}, rsp_data, e.res);
      chk({tag, "_rsp_id"}, rsp_id, e.id);
    end
  endtask

  initial begin
    int g, n, grants, rsps, ncyc, w, since, ptr;
    logic [15:0] cap_d;
    logic [1:0]  cap_id;
    logic free, exp_rv, xfer;
    logic [3:0] exp_rr;

    rst = 1'b1;
    req_valid = 4'hF;
    req_data = '0;
    req_amt = '0;
    req_dir = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cur_data[i] = '0; cur_amt[i] = '0; cur_dir[i] = 1'b0;
    end

    // Reset state, with requests pending to show they are not granted during reset.
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_sh_a", sh_a, 0);
    chk("reset_sh_s", sh_s, 0);
    chk("reset_sh_sel", sh_sel, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_id", rsp_id, 0);
    req_valid = '0;
    tick;
    rst = 1'b0;
    tick;

    // Table-driven single-requester operations with hand-computed results.
    vecs[0] = '{1, 16'h00F1, 4'd4,  1'b0, 16'h0F10};
    vecs[1] = '{2, 16'h8001, 4'd15, 1'b1, 16'h0001};
    vecs[2] = '{3, 16'h8001, 4'd0,  1'b1, 16'h8001};
    vecs[3] = '{0, 16'h8001, 4'd15, 1'b0, 16'h8000};
    vecs[4] = '{2, 16'hABCD, 4'd8,  1'b1, 16'h00AB};
    vecs[5] = '{0, 16'h1234, 4'd1,  1'b0, 16'h2468};
    vecs[6] = '{3, 16'hFFFF, 4'd15, 1'b0, 16'h8000};
    for (int v = 0; v < 7; v++) begin
      set_op(vecs[v].id, vecs[v].data, vecs[v].amt, vecs[v].dir);
      @(negedge clk);
      chk("vec_req_ready", req_ready, 4'(1) << vecs[v].id);
      tick;
      req_valid = '0;
      @(negedge clk);
      chk("vec_shift_rsp_valid", rsp_valid, 0);
      chk("vec_shift_busy", busy, 1);
      tick;
      @(negedge clk);
      chk("vec_rsp_valid", rsp_valid, 1);
      chk("vec_rsp_data", rsp_data, vecs[v].exp);
      chk("vec_rsp_id", rsp_id, vecs[v].id);
      tick;
      @(negedge clk);
      chk("vec_idle_after", busy, 0);
      tick;
    end

    // Single requester held valid: grants land exactly every 3 cycles.
    set_op(1, 16'h00F1, 4'd4, 1'b0);
    grants = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready[1]) begin
        chk("cadence_cycle", c, grants * 3);
        grants++;
      end
      tick;
    end
    chk("cadence_count", grants, 4);
    drain;

    // All four requesters continuously valid: strict rotation from requester 0.
    do_reset;
    expq.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, op_data(i, 0), 4'(i + 1), i[0]);
    grants = 0;
    rsps = 0;
    ncyc = 0;
    while (rsps < 12 && ncyc < 200) begin
      @(negedge clk);
      g = -1;
      for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
      if (g >= 0) begin
        chk("rr_onehot", $countones(req_ready), 1);
        chk("rr_order", g, grants % 4);
        expq.push_back('{g, ref_shift(cur_data[g], cur_amt[g], cur_dir[g])});
        grants++;
      end
      if (rsp_valid && rsp_ready) begin
        pop_check("rr");
        rsps++;
      end
      tick;
      ncyc++;
      if (g >= 0) begin
        if (grants < 12) set_op(g, op_data(g, grants), 4'(grants % 16), grants[1]);
        else req_valid[g] = 1'b0;
      end
    end
    chk("rr_rsp_count", rsps, 12);

    // Backpressure: result held stable and no grants while the consumer stalls.
    for (int i = 0; i < 4; i++) set_op(i, op_data(i, 50), 4'd3, 1'b1);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_grant0", req_ready, 4'b0001);
    tick;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp_shift_valid", rsp_valid, 0);
    tick;
    @(negedge clk);
    cap_d = rsp_data;
    cap_id = rsp_id;
    chk("bp_rsp_data", rsp_data, ref_shift(op_data(0, 50), 4'd3, 1'b1));
    chk("bp_rsp_id", rsp_id, 0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, cap_d);
      chk("bp_hold_id", rsp_id, cap_id);
      chk("bp_no_ready", req_ready, 0);
    end
    tick;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", rsp_valid, 1);
    chk("bp_release_data", rsp_data, cap_d);
    tick;
    @(negedge clk);
    chk("bp_idle_after", busy, 0);
    chk("bp_next_grant", req_ready, 4'b0010);

    // Reset asserted between edges while a response is waiting.
    tick;
    for (int i = 0; i < 4; i++) set_op(i, op_data(i, 60), 4'd1, 1'b0);
    rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick;
      n++;
    end
    chk("rst_pre_valid", rsp_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_req_ready", req_ready, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_next_grant", req_ready, 4'b0001);
    drain;

    // Randomized traffic against a transaction-level model.
    do_reset;
    expq.delete();
    req_valid = '0;
    free = 1'b1;
    since = 0;
    ptr = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(2) == 0) set_op(i, 16'($urandom), 4'($urandom_range(15)), 1'($urandom_range(1)));
        end else if ($urandom_range(15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      w = free ? ref_winner(req_valid, ptr) : -1;
      exp_rr = (w >= 0) ? (4'(1) << w) : 4'b0000;
      exp_rv = !free && (since >= 2);
      xfer = exp_rv && rsp_ready;
      chk("rnd_req_ready", req_ready, exp_rr);
      chk("rnd_rsp_valid", rsp_valid, exp_rv);
      chk("rnd_busy", busy, !free);
      if (xfer) pop_check("rnd");
      if (w >= 0) expq.push_back('{w, ref_shift(cur_data[w], cur_amt[w], cur_dir[w])});
      tick;
      since++;
      if (w >= 0) begin
        req_valid[w] = 1'b0;
        ptr = (w + 1) % 4;
        free = 1'b0;
        since = 1;
      end
      if (xfer) free = 1'b1;
    end
    drain;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
